mem_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Registers the execute-to-memory bus (EX/MEM pipeline register) and extracts and extends load data from the synchronous data SRAM.
- Resolves the instruction's exception state and raises a precise exception request towards CP0 and the flush logic.
- Produces the write-back bus and the register-file/HI-LO forwarding bus.

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage_load_align.sv | 30 +++
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus field indices and CP0 exception codes for the MEM stage.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 167;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_RF_WD = 72;

  // exceptinfo bit indices
  localparam int EI_FETCH_ADEL = 9;
  localparam int EI_ADES       = 8;
  localparam int EI_ADEL       = 7;
  localparam int EI_OV         = 6;
  localparam int EI_ERET       = 5;
  localparam int EI_RI         = 4;
  localparam int EI_BP         = 3;
  localparam int EI_SYS        = 2;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // mem_op one-hot bit positions (MSB first: lb lbu lh lhu lw sb sh sw)
  localparam int MOP_LB  = 7;
  localparam int MOP_LBU = 6;
  localparam int MOP_LH  = 5;
  localparam int MOP_LHU = 4;
  localparam int MOP_LW  = 3;

  // hilo_bus = {hi_we, lo_we, hi[31:0], lo[31:0]}
  localparam int HILO_HI_WE = 65;
  localparam int HILO_LO_WE = 64;

  typedef struct packed {
    logic [15:0] exceptinfo;
    logic [7:0]  mem_op;
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        ram_en;
    logic        ram_wen;
    logic [3:0]  ram_sel;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-path bundle between execute, data SRAM, MEM stage, write-back and CP0.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
  logic                    except_req;
  logic [4:0]              except_code;
  logic                    except_is_eret;
  logic [31:0]             bad_vaddr;
  logic [31:0]             mem_pc;

  // No handshake: the bundle follows the pipeline's stall/flush controls, one instruction per cycle.
  modport master (
    output ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus, except_req, except_code,
           except_is_eret, bad_vaddr, mem_pc
  );

  modport slave (
    input  ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus, except_req, except_code,
           except_is_eret, bad_vaddr, mem_pc
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of the SRAM word and sign- or zero-extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_store_ops;

  assign shifted          = rdata >> {addr, 3'b000};
  assign byte_v           = shifted[7:0];
  assign half_v           = addr[1] ? rdata[31:16] : rdata[15:0];
  assign unused_store_ops = ^mem_op[2:0];

  always_comb begin
    load_data = '0;
    if (mem_op[MOP_LB])       load_data = {{24{byte_v[7]}}, byte_v};
    else if (mem_op[MOP_LBU]) load_data = {24'h0, byte_v};
    else if (mem_op[MOP_LH])  load_data = {{16{half_v[15]}}, half_v};
    else if (mem_op[MOP_LHU]) load_data = {16'h0, half_v};
    else if (mem_op[MOP_LW])  load_data = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM register, load extraction, precise exception resolution.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stall_ex,
  input  logic       stall_mem,
  mem_stage_if.slave io
);

  ex_mem_t     r;
  logic        valid;
  logic [31:0] rbuf;
  logic        rbuf_v;
  logic        advance;
  logic        is_load;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] result;
  logic [15:0] ei;
  logic        exc_any;
  logic        eret;
  logic        kill;
  logic [65:0] hilo_o;
  logic        rf_we_o;
  logic        unused_fields;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r     <= '0;
      valid <= 1'b0;
    end else if (stall_ex && !stall_mem) begin
      r     <= '0;
      valid <= 1'b0;
    end else if (!stall_ex) begin
      r     <= ex_mem_t'(io.ex_to_mem_bus);
      valid <= 1'b1;
    end
  end

  // SRAM data is only valid one cycle after the address; hold it while stalled.
  assign advance = !stall_ex || !stall_mem;
  assign is_load = |r.mem_op[MOP_LB:MOP_LW];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rbuf   <= '0;
      rbuf_v <= 1'b0;
    end else if (advance) begin
      rbuf_v <= 1'b0;
    end else if (valid && is_load && !rbuf_v) begin
      rbuf   <= io.data_sram_rdata;
      rbuf_v <= 1'b1;
    end
  end

  assign load_word = rbuf_v ? rbuf : io.data_sram_rdata;

  mem_stage_load_align u_align (
    .mem_op    (r.mem_op),
    .addr      (r.ex_result[1:0]),
    .rdata     (load_word),
    .load_data (load_data)
  );

  assign result = r.sel_rf_res ? load_data : r.ex_result;
  assign ei     = r.exceptinfo;

  assign exc_any = valid && (ei[EI_FETCH_ADEL] || ei[EI_ADES] || ei[EI_ADEL] ||
                             ei[EI_OV] || ei[EI_RI] || ei[EI_BP] || ei[EI_SYS]);
  assign eret    = valid && ei[EI_ERET] && !exc_any;
  assign kill    = exc_any || eret;

  always_comb begin
    io.except_code = '0;
    io.bad_vaddr   = '0;
    if (valid) begin
      if (ei[EI_FETCH_ADEL]) begin
        io.except_code = EXC_ADEL;
        io.bad_vaddr   = r.pc;
      end else if (ei[EI_RI]) begin
        io.except_code = EXC_RI;
      end else if (ei[EI_SYS]) begin
        io.except_code = EXC_SYS;
      end else if (ei[EI_BP]) begin
        io.except_code = EXC_BP;
      end else if (ei[EI_OV]) begin
        io.except_code = EXC_OV;
      end else if (ei[EI_ADEL]) begin
        io.except_code = EXC_ADEL;
        io.bad_vaddr   = r.ex_result;
      end else if (ei[EI_ADES]) begin
        io.except_code = EXC_ADES;
        io.bad_vaddr   = r.ex_result;
      end
    end
  end

  // A faulting or eret instruction must not commit architectural state.
  always_comb begin
    hilo_o = r.hilo_bus;
    if (kill) begin
      hilo_o[HILO_HI_WE] = 1'b0;
      hilo_o[HILO_LO_WE] = 1'b0;
    end
  end

  assign rf_we_o = r.rf_we && !kill;

  assign io.mem_to_wb_bus  = {hilo_o, r.pc, rf_we_o, r.rf_waddr, result};
  assign io.mem_to_rf_bus  = {hilo_o, rf_we_o, r.rf_waddr};
  assign io.except_req     = exc_any;
  assign io.except_is_eret = eret;
  assign io.mem_pc         = r.pc;

  assign unused_fields = ^{r.ram_en, r.ram_wen, r.ram_sel, ei[15:10], ei[1:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a field-level reference model.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst, flush, stall_ex, stall_mem;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if io ();

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall_ex  (stall_ex),
    .stall_mem (stall_mem),
    .io        (io)
  );

  always #5 clk = ~clk;

  // Reference state: the instruction held in the stage and any held load word.
  logic         m_v;
  logic [166:0] m_bus;
  logic         m_rbuf_v;
  logic [31:0]  m_rbuf;

  logic [135:0] o_wb;
  logic         o_req;
  logic [4:0]   o_code;
  logic [31:0]  o_bva;

  function automatic logic [166:0] mk(input logic [15:0] ei, input logic [7:0] op,
                                      input logic [65:0] hilo, input logic [31:0] pc,
                                      input logic sel, input logic we, input logic [4:0] wa,
                                      input logic [31:0] res);
    return {ei, op, hilo, pc, |op, |op[2:0], 4'hf, sel, we, wa, res};
  endfunction

  function automatic void model_out(input logic v, input logic [166:0] b, input logic [31:0] word,
                                    output logic [135:0] wb, output logic [71:0] rf,
                                    output logic req, output logic [4:0] code,
                                    output logic eret, output logic [31:0] bva,
                                    output logic [31:0] pc);
    logic [15:0] ei;
    logic [7:0]  op;
    logic [65:0] hilo;
    logic [31:0] res, ld, result;
    logic [7:0]  bytev;
    logic [15:0] halfv;
    int          a;
    ei = b[166:151]; op = b[150:143]; hilo = b[142:77]; pc = b[76:45]; res = b[31:0];
    wb = '0; rf = '0; req = 1'b0; code = '0; eret = 1'b0; bva = '0;
    if (!v) begin
      pc = '0;
      return;
    end
    a = int'(res[1:0]);
    bytev = 8'(word >> (8 * a));
    halfv = 16'(word >> (16 * (a / 2)));
    ld = 32'h0;
    if (op[7])      ld = {{24{bytev[7]}}, bytev};
    else if (op[6]) ld = {24'h0, bytev};
    else if (op[5]) ld = {{16{halfv[15]}}, halfv};
    else if (op[4]) ld = {16'h0, halfv};
    else if (op[3]) ld = word;
    result = b[38] ? ld : res;
    if (ei[9])      begin code = 5'h04; bva = pc;  end
    else if (ei[4]) code = 5'h0a;
    else if (ei[2]) code = 5'h08;
    else if (ei[3]) code = 5'h09;
    else if (ei[6]) code = 5'h0c;
    else if (ei[7]) begin code = 5'h04; bva = res; end
    else if (ei[8]) begin code = 5'h05; bva = res; end
    req  = |{ei[9:6], ei[4:2]};
    eret = ei[5] && !req;
    if (req || eret) hilo[65:64] = 2'b00;
    wb = {hilo, pc, b[37] && !(req || eret), b[36:32], result};
    rf = {hilo, b[37] && !(req || eret), b[36:32]};
  endfunction

  task automatic model_step(input logic r_i, input logic fl, input logic se, input logic sm,
                            input logic [166:0] b, input logic [31:0] rd);
    if (r_i || fl) begin
      m_v = 1'b0; m_bus = '0; m_rbuf_v = 1'b0; m_rbuf = '0;
    end else begin
      if (!se || !sm) m_rbuf_v = 1'b0;
      else if (m_v && (|m_bus[150:146]) && !m_rbuf_v) begin
        m_rbuf = rd; m_rbuf_v = 1'b1;
      end
      if (se && !sm) begin
        m_v = 1'b0; m_bus = '0;
      end else if (!se) begin
        m_v = 1'b1; m_bus = b;
      end
    end
  endtask

  // One cycle: drive at negedge, compare outputs, then advance the model on the posedge.
  task automatic do_cycle(input logic r_i, input logic fl, input logic se, input logic sm,
                          input logic [166:0] b, input logic [31:0] rd, input string tag);
    logic [135:0] e_wb;
    logic [71:0]  e_rf;
    logic         e_req, e_eret;
    logic [4:0]   e_code;
    logic [31:0]  e_bva, e_pc;
    @(negedge clk);
    rst = r_i; flush = fl; stall_ex = se; stall_mem = sm;
    io.ex_to_mem_bus = b; io.data_sram_rdata = rd;
    #1;
    model_out(m_v, m_bus, m_rbuf_v ? m_rbuf : rd, e_wb, e_rf, e_req, e_code, e_eret, e_bva, e_pc);
    checks += 7;
    if (io.mem_to_wb_bus !== e_wb) begin
      errors++; $display("FAIL %s wb_bus got %h exp %h", tag, io.mem_to_wb_bus, e_wb);
    end
    if (io.mem_to_rf_bus !== e_rf) begin
      errors++; $display("FAIL %s rf_bus got %h exp %h", tag, io.mem_to_rf_bus, e_rf);
    end
    if (io.except_req !== e_req) begin
      errors++; $display("FAIL %s except_req got %b exp %b", tag, io.except_req, e_req);
    end
    if (io.except_code !== e_code) begin
      errors++; $display("FAIL %s except_code got %h exp %h", tag, io.except_code, e_code);
    end
    if (io.except_is_eret !== e_eret) begin
      errors++; $display("FAIL %s eret got %b exp %b", tag, io.except_is_eret, e_eret);
    end
    if (io.bad_vaddr !== e_bva) begin
      errors++; $display("FAIL %s bad_vaddr got %h exp %h", tag, io.bad_vaddr, e_bva);
    end
    if (io.mem_pc !== e_pc) begin
      errors++; $display("FAIL %s mem_pc got %h exp %h", tag, io.mem_pc, e_pc);
    end
    o_wb = io.mem_to_wb_bus; o_req = io.except_req; o_code = io.except_code; o_bva = io.bad_vaddr;
    @(posedge clk);
    model_step(r_i, fl, se, sm, b, rd);
  endtask

  task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    io.ex_to_mem_bus = '0; io.data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    m_v = 1'b0; m_bus = '0; m_rbuf_v = 1'b0; m_rbuf = '0;
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, 32'hFFFF_FFFF, "reset");
    expect32("reset_wb_lo", o_wb[31:0], 32'h0);
    expect32("reset_req", {31'h0, o_req}, 32'h0);
  endtask

  task automatic test_load_ext();
    do_cycle(0, 0, 0, 0, mk(16'h0, 8'h80, '0, 32'h0040_0000, 1, 1, 5'd3, 32'h8000_0003), 32'h0, "lb_cap");
    do_cycle(0, 0, 0, 0, mk(16'h0, 8'h40, '0, 32'h0040_0004, 1, 1, 5'd4, 32'h8000_0003), 32'h80AA_BBCC, "lb");
    expect32("lb_result", o_wb[31:0], 32'hFFFF_FF80);
    expect32("lb_rf_we", {31'h0, o_wb[37]}, 32'h1);
    do_cycle(0, 0, 0, 0, '0, 32'h80AA_BBCC, "lbu");
    expect32("lbu_result", o_wb[31:0], 32'h0000_0080);
  endtask

  task automatic test_stall_hold();
    do_cycle(0, 0, 0, 0, mk(16'h0, 8'h20, '0, 32'h0040_0010, 1, 1, 5'd5, 32'h1000_0002), 32'h0, "lh_cap");
    do_cycle(0, 0, 1, 1, '0, 32'h1234_8765, "lh_s0");
    expect32("lh_stall0", o_wb[31:0], 32'h0000_1234);
    for (int i = 1; i < 3; i++) begin
      do_cycle(0, 0, 1, 1, '0, 32'hDEAD_BEEF, "lh_s");
      expect32("lh_stall_hold", o_wb[31:0], 32'h0000_1234);
    end
    do_cycle(0, 0, 0, 0, '0, 32'hDEAD_BEEF, "lh_release");
    expect32("lh_release", o_wb[31:0], 32'h0000_1234);
  endtask

  task automatic test_bubble();
    logic [166:0] x;
    x = mk(16'h0, 8'h0, {2'b11, 32'hAAAA_0001, 32'h5555_0002}, 32'h0040_0020, 0, 1, 5'd7, 32'hCAFE_0001);
    do_cycle(0, 0, 0, 0, x, 32'h0, "bub_pre");
    do_cycle(0, 0, 1, 0, x, 32'h0, "bub_edge");
    do_cycle(0, 0, 0, 0, x, 32'h0, "bubble");
    expect32("bubble_wb_res", o_wb[31:0], 32'h0);
    expect32("bubble_req", {31'h0, o_req}, 32'h0);
    do_cycle(0, 0, 1, 1, '0, 32'h0, "bub_after");
    expect32("bub_after_res", o_wb[31:0], 32'hCAFE_0001);
    expect32("bub_after_pc", o_wb[69:38], 32'h0040_0020);
  endtask

  task automatic test_exceptions();
    logic [166:0] x;
    x = mk(16'h00C0, 8'h0, {2'b11, 64'h1}, 32'hBFC0_0100, 0, 1, 5'd9, 32'h0000_0011);
    do_cycle(0, 0, 0, 0, x, 32'h0, "ov_cap");
    do_cycle(0, 0, 0, 0, mk(16'h0200, 8'h0, {2'b11, 64'h1}, 32'hBFC0_0100, 0, 1, 5'd9, 32'h0000_0011),
             32'h0, "ov");
    expect32("ov_code", {27'h0, o_code}, 32'h0c);
    expect32("ov_kill_we", {29'h0, o_wb[135], o_wb[134], o_wb[37]}, 32'h0);
    do_cycle(0, 0, 0, 0, mk(16'h0100, 8'h01, '0, 32'hBFC0_0200, 0, 0, 5'd0, 32'h1000_0002),
             32'h0, "fetch_adel");
    expect32("fetch_adel_code", {27'h0, o_code}, 32'h04);
    expect32("fetch_adel_bva", o_bva, 32'hBFC0_0100);
    do_cycle(0, 1, 0, 0, mk(16'h0004, 8'h0, '0, 32'h0, 0, 1, 5'd1, 32'h1), 32'h0, "ades_flush");
    expect32("ades_code", {27'h0, o_code}, 32'h05);
    expect32("ades_bva", o_bva, 32'h1000_0002);
    do_cycle(0, 0, 1, 1, '0, 32'h0, "post_flush");
    expect32("post_flush_req", {31'h0, o_req}, 32'h0);
    expect32("post_flush_wb", o_wb[31:0], 32'h0);
  endtask

  task automatic test_reset_mid_stall();
    do_cycle(0, 0, 0, 0, mk(16'h0, 8'h08, '0, 32'h0040_0040, 1, 1, 5'd2, 32'h0000_0100), 32'h0, "rs_cap");
    do_cycle(0, 0, 1, 1, '0, 32'h1111_2222, "rs_latch");
    do_cycle(1, 0, 1, 1, '0, 32'h3333_4444, "rs_rst");
    do_cycle(0, 0, 0, 0, mk(16'h0, 8'h08, '0, 32'h0040_0050, 1, 1, 5'd2, 32'h0000_0104), 32'h5555_6666, "rs_zero");
    expect32("rs_zero_wb", o_wb[31:0], 32'h0);
    expect32("rs_zero_pc", o_wb[69:38], 32'h0);
    do_cycle(0, 0, 1, 1, '0, 32'h1357_9BDF, "rs_live");
    expect32("rs_live_res", o_wb[31:0], 32'h1357_9BDF);
  endtask

  task automatic test_random();
    logic [166:0] b;
    logic [15:0]  ei;
    logic [7:0]   op;
    int           k;
    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 8);
      op = (k < 8) ? 8'(1 << k) : 8'h0;
      ei = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      if ($urandom_range(0, 7) == 0) ei = ei | 16'(1 << $urandom_range(2, 9));
      b = mk(ei, op, {2'($urandom), $urandom, $urandom}, $urandom, (k >= 3 && k <= 7), 1'($urandom),
             5'($urandom), $urandom);
      do_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, b, $urandom, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_stall_hold();
    test_bubble();
    test_exceptions();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
